// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access,
// routing in-order responses back via a FIFO of source IDs.
module sram_bus_arbiter #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic          i_addr_ok,
    output logic          i_data_ok,
    output logic [31:0]   i_rdata,

    input  logic          d_req,
    input  logic          d_wr,
    input  logic [1:0]    d_size,
    input  logic [3:0]    d_wstrb,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_addr_ok,
    output logic          d_data_ok,
    output logic [31:0]   d_rdata,

    output logic          m_req,
    output logic          m_wr,
    output logic [1:0]    m_size,
    output logic [3:0]    m_wstrb,
    output logic [31:0]   m_addr,
    output logic [31:0]   m_wdata,
    input  logic          m_addr_ok,
    input  logic          m_data_ok,
    input  logic [31:0]   m_rdata,

    output logic [CW-1:0] outstanding,
    output logic          err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        LK_IDLE,
        LK_FETCH,
        LK_DATA
    } lock_e;

    typedef enum logic [1:0] {
        GR_NONE,
        GR_FETCH,
        GR_DATA
    } grant_e;

    lock_e             lock_q, lock_d;
    logic [DEPTH-1:0]  src_q, src_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              err_q, err_d;

    grant_e            grant;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              head_src;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign head_src = src_q[rd_ptr_q];

    // A stalled request keeps the bus until accepted, even if the other side asks.
    always_comb begin
        grant = GR_NONE;
        case (lock_q)
            LK_FETCH: grant = GR_FETCH;
            LK_DATA:  grant = GR_DATA;
            default: begin
                if (d_req) begin
                    grant = GR_DATA;
                end else if (i_req) begin
                    grant = GR_FETCH;
                end
            end
        endcase
    end

    always_comb begin
        m_req   = 1'b0;
        m_wr    = 1'b0;
        m_size  = '0;
        m_wstrb = '0;
        m_addr  = '0;
        m_wdata = '0;
        case (grant)
            GR_FETCH: begin
                m_req  = !full && i_req;
                m_size = 2'd2;
                m_addr = i_addr;
            end
            GR_DATA: begin
                m_req   = !full && d_req;
                m_wr    = d_wr;
                m_size  = d_size;
                m_wstrb = d_wstrb;
                m_addr  = d_addr;
                m_wdata = d_wdata;
            end
            default: ;
        endcase
    end

    assign push      = m_req && m_addr_ok;
    assign pop       = m_data_ok && !empty;

    assign i_addr_ok = push && (grant == GR_FETCH);
    assign d_addr_ok = push && (grant == GR_DATA);
    assign i_data_ok = pop && !head_src;
    assign d_data_ok = pop && head_src;
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;

    assign outstanding = count_q;
    assign err         = err_q;

    always_comb begin
        lock_d   = lock_q;
        src_d    = src_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;

        if (push) begin
            lock_d = LK_IDLE;
        end else if (m_req) begin
            lock_d = (grant == GR_DATA) ? LK_DATA : LK_FETCH;
        end

        if (push) begin
            src_d[wr_ptr_q] = (grant == GR_DATA);
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // Push and pop together leave the count alone; pointers still advance.
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (m_data_ok && empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q   <= LK_IDLE;
            src_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            lock_q   <= lock_d;
            src_q    <= src_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: per-cycle expected grants and a
// queue of expected responses (source ID + read data) popped on m_data_ok.
module tb_sram_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_addr_ok;
    logic        i_data_ok;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;
    logic [2:0]  outstanding;
    logic        err;

    sram_bus_arbiter #(.DEPTH(4), .CW(3)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_addr_ok(d_addr_ok),
        .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok),
        .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .outstanding(outstanding), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        src;
        logic [31:0] data;
    } resp_t;

    resp_t exp_q[$];
    int    exp_cnt;
    logic  exp_err;
    int    n_cmp;
    int    n_bad;

    localparam int G_NONE  = 0;
    localparam int G_FETCH = 1;
    localparam int G_DATA  = 2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_idle();
        i_req = 0; i_addr = '0;
        d_req = 0; d_wr = 0; d_size = '0; d_wstrb = '0; d_addr = '0; d_wdata = '0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        exp_err = 1'b0;
        #2;
        check_eq("rst_outstanding", 32'(outstanding), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_m_req", 32'(m_req), 32'd0);
        check_eq("rst_m_addr", m_addr, 32'd0);
        check_eq("rst_addr_ok", {30'd0, i_addr_ok, d_addr_ok}, 32'd0);
        check_eq("rst_data_ok", {30'd0, i_data_ok, d_data_ok}, 32'd0);
    endtask

    // One bus cycle: drive, check combinational outputs, clock, check state.
    task automatic cyc(input bit fr, input logic [31:0] fa, input bit dr, input bit dwr,
                       input logic [31:0] da, input bit maok, input bit mdok, input int g,
                       input logic [31:0] rdata_new);
        bit    full_m, mreq_m, acc, have;
        resp_t r;
        r = '0;
        i_req = fr; i_addr = fa;
        d_req = dr; d_wr = dwr; d_addr = da;
        d_size  = dwr ? 2'd1 : 2'd2;
        d_wstrb = dwr ? 4'h3 : 4'h0;
        d_wdata = da ^ 32'hA5A5_0000;
        m_addr_ok = maok; m_data_ok = mdok;
        have = mdok && (exp_q.size() > 0);
        if (have) r = exp_q[0];
        m_rdata = have ? r.data : $urandom();
        #2;
        full_m = (exp_cnt == 4);
        mreq_m = (g != G_NONE) && !full_m;
        acc    = mreq_m && maok;
        check_eq("m_req", 32'(m_req), 32'(mreq_m));
        check_eq("i_addr_ok", 32'(i_addr_ok), 32'(acc && g == G_FETCH));
        check_eq("d_addr_ok", 32'(d_addr_ok), 32'(acc && g == G_DATA));
        check_eq("m_addr", m_addr, (g == G_FETCH) ? fa : (g == G_DATA) ? da : 32'd0);
        check_eq("m_wr", 32'(m_wr), 32'((g == G_DATA) && dwr));
        check_eq("m_size", 32'(m_size),
                 (g == G_FETCH) ? 32'd2 : (g == G_DATA) ? 32'(d_size) : 32'd0);
        check_eq("m_wstrb", 32'(m_wstrb), (g == G_DATA) ? 32'(d_wstrb) : 32'd0);
        check_eq("m_wdata", m_wdata, (g == G_DATA) ? (da ^ 32'hA5A5_0000) : 32'd0);
        check_eq("i_data_ok", 32'(i_data_ok), 32'(have && !r.src));
        check_eq("d_data_ok", 32'(d_data_ok), 32'(have && r.src));
        if (have) begin
            check_eq(r.src ? "d_rdata" : "i_rdata", r.src ? d_rdata : i_rdata, r.data);
        end
        if (mdok && !have) exp_err = 1'b1;
        @(posedge clk);
        #1;
        if (have) void'(exp_q.pop_front());
        if (acc) exp_q.push_back('{src: (g == G_DATA), data: rdata_new});
        exp_cnt = exp_cnt + int'(acc) - int'(have);
        check_eq("outstanding", 32'(outstanding), 32'(exp_cnt));
        check_eq("err", 32'(err), 32'(exp_err));
    endtask

    task automatic idle_cyc(input bit mdok);
        cyc(0, '0, 0, 0, '0, 0, mdok, G_NONE, '0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        exp_cnt = 0; exp_err = 1'b0;
        reset = 1'b1;
        drive_idle();
        do_reset();

        // Single fetch, response two cycles later
        cyc(1, 32'h1C00_0000, 0, 0, '0, 1, 0, G_FETCH, 32'h0280_0C0C);
        idle_cyc(0);
        idle_cyc(1);

        // Contention: data wins, then fetch; responses in order
        cyc(1, 32'h1C00_0004, 1, 0, 32'h1C01_0000, 1, 0, G_DATA, 32'h1111_2222);
        cyc(1, 32'h1C00_0004, 0, 0, '0, 1, 0, G_FETCH, 32'h3333_4444);
        idle_cyc(1);
        idle_cyc(1);

        // Lock: stalled fetch holds the bus while data request appears
        cyc(1, 32'h1C00_0100, 0, 0, '0, 0, 0, G_FETCH, '0);
        cyc(1, 32'h1C00_0100, 1, 1, 32'h0000_2000, 0, 0, G_FETCH, '0);
        cyc(1, 32'h1C00_0100, 1, 1, 32'h0000_2000, 0, 0, G_FETCH, '0);
        cyc(1, 32'h1C00_0100, 1, 1, 32'h0000_2000, 1, 0, G_FETCH, 32'hAAAA_0001);
        cyc(0, '0, 1, 1, 32'h0000_2000, 1, 0, G_DATA, 32'hAAAA_0002);
        idle_cyc(1);
        idle_cyc(1);

        // Full: four fetches, fifth blocked, pop does not unblock same cycle
        for (int i = 0; i < 4; i++) begin
            cyc(1, 32'h1C00_0200 + 32'(i * 4), 0, 0, '0, 1, 0, G_FETCH, 32'hF000_0000 + 32'(i));
        end
        cyc(1, 32'h1C00_0210, 0, 0, '0, 1, 0, G_FETCH, '0);
        cyc(1, 32'h1C00_0210, 0, 0, '0, 1, 1, G_FETCH, '0);
        cyc(1, 32'h1C00_0210, 0, 0, '0, 1, 0, G_FETCH, 32'hF000_0004);
        for (int i = 0; i < 4; i++) idle_cyc(1);

        // Wrap: alternating requests, each answered in the following cycle
        for (int i = 0; i <= 10; i++) begin
            bit fr, dr;
            fr = (i < 10) && (i % 2 == 0);
            dr = (i < 10) && (i % 2 == 1);
            cyc(fr, 32'h1C00_1000 + 32'(i * 4), dr, 0, 32'h0000_3000 + 32'(i * 4), 1, i > 0,
                fr ? G_FETCH : dr ? G_DATA : G_NONE, 32'($urandom()));
        end

        // Spurious response sets sticky err
        idle_cyc(1);
        idle_cyc(0);
        cyc(1, 32'h1C00_0400, 0, 0, '0, 1, 0, G_FETCH, 32'h5555_AAAA);
        idle_cyc(1);
        check_eq("err_sticky", 32'(err), 32'd1);

        // Reset with a request in flight clears everything
        cyc(0, '0, 1, 0, 32'h0000_4000, 1, 0, G_DATA, 32'h7777_8888);
        do_reset();
        idle_cyc(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
